instr_download_ctrl: RTL and testbench
======================================

// Module: instr_download_ctrl
// PURPOSE
//  XT_HB slave that streams user program bytes into the user instruction RAM while in download mode.
//  Boot firmware writes bytes to DATA; the block packs 4 bytes little-endian into a word and writes it to
//  imem at an auto-incrementing word address, keeping a running byte checksum.
//  Feeds user_instruction memory, which the boot/run mode switch later selects once the load is complete.
// PARAMETERS
//  IMEM_WORDS  2048  user instruction RAM depth in 32-bit words; AW = $clog2(IMEM_WORDS)
// PORTS
//  hb_clk       in   1   bus clock; the only clock
//  rst_sync     in   1   synchronous, active-high reset
//  xt_hb        in   hb_slave_t  XT_HB slave bundle: raddr, waddr, wdata
//  sel          in   sel_t       per-slave ren/wen strobes
//  rdata        out  32  registered read data
//  download_mode in  1   high = downloads permitted; DATA writes ignored when low
//  imem_we      out  1   word write request to instruction RAM
//  imem_addr    out  AW  word address of request
//  imem_wdata   out  32  packed word
//  imem_ready   in   1   RAM accepts request in the cycle imem_we && imem_ready
// BEHAVIOUR
//  Register map (offset[1:0]): 00 CTRL/STAT, 01 DATA (W), 10 ADDR (R/W), 11 CKSUM (R).
//  CTRL write: bit0 START -> addr=0, byte_cnt=0, cksum=0, flags cleared, state LOAD; bit1 FINISH -> FLUSH.
//   START and FINISH together: START wins. START in any state aborts a pending write (imem_we drops next cycle).
//  STAT read: {26'b0, drop_err, ovf, pending, state[1:0], download_mode}.
//  States: IDLE (reset) -> LOAD on START; LOAD -> WRITE when 4th byte packed; WRITE -> LOAD on accept;
//   LOAD -> FLUSH on FINISH; FLUSH: if byte_cnt!=0 issue zero-padded word (upper bytes 0), then IDLE.
//  DATA write in LOAD with download_mode=1: byte into lane byte_cnt, byte_cnt++, cksum += {24'b0,wdata[7:0]} mod 2^32.
//  DATA write in WRITE/FLUSH: byte dropped, drop_err sticky set, cksum unchanged. In IDLE: ignored, no flag.
//  Write: imem_we asserted from the cycle after 4th byte; held with stable addr/data until imem_ready.
//   On accept: addr++, byte_cnt=0. Minimum 1 cycle between 4th byte and next DATA accept (ready=1 same cycle).
//  Overflow: word write with addr==IMEM_WORDS-1 accepted -> ovf sticky; further words not issued,
//   bytes still counted in cksum. addr does not wrap (stays IMEM_WORDS-1).
//  ADDR write only in IDLE (sets word addr, clears ovf); ignored otherwise. ADDR read = {0, addr}.
//  rdata: 1-cycle latency, registered on sel.ren; 0 in any cycle without sel.ren. DATA reads return 0.
//  Reset: state IDLE, imem_we=0, imem_addr=0, imem_wdata=0, rdata=0, cksum=0, byte_cnt=0, all flags 0.
//  Reset mid-write: request dropped immediately; RAM contents not guaranteed for that word.
//  Simultaneous read and write of same register: read returns pre-write value.
// STRUCTURE
//  Register offsets, state enum dl_state_e, STAT bit positions: shared package XT_DL (uses XT_BUS types).
//  Sub-module dl_word_packer: byte lane shift-in, byte_cnt, zero-pad flush, full flag. FSM/bus decode in top.
// TESTING
//  START, DATA 0x11,0x22,0x33,0x44, imem_ready=1 -> one imem_we, addr 0, wdata 0x44332211; CKSUM=0xAA; ADDR=1.
//  imem_ready low 5 cycles after 4th byte -> imem_we/addr/data stable 5 cycles; DATA write meanwhile -> drop_err=1.
//  START, DATA 0xAB,0xCD, FINISH -> write wdata 0x0000CDAB at addr 0, state IDLE, ADDR=1.
//  IMEM_WORDS=4, START, 20 bytes -> exactly 4 writes (addr 0..3), ovf=1, CKSUM = sum of all 20 bytes.
//  download_mode=0 during DATA writes -> no imem_we, byte_cnt and CKSUM unchanged; STAT bit0=0.
//  rst_sync pulsed while imem_we=1 -> next cycle imem_we=0, STAT reads 0x0 (with download_mode=0), ADDR=0.

Source files
------------

// File: rtl/instr_download_ctrl_pkg.sv
// Shared types for the instruction download path: bus bundles, register offsets, FSM states, STAT layout.
// Pure declarations, no timing or flow control of its own.
`timescale 1ns/1ps
package instr_download_ctrl_pkg;

  localparam int HB_AW = 4;

  typedef struct packed {
    logic [HB_AW-1:0] raddr;
    logic [HB_AW-1:0] waddr;
    logic [31:0]      wdata;
  } hb_slave_t;

  typedef struct packed {
    logic ren;
    logic wen;
  } sel_t;

  typedef enum logic [1:0] {
    DL_IDLE  = 2'd0,
    DL_LOAD  = 2'd1,
    DL_WRITE = 2'd2,
    DL_FLUSH = 2'd3
  } dl_state_e;

  localparam logic [1:0] REG_CTRL  = 2'b00;
  localparam logic [1:0] REG_DATA  = 2'b01;
  localparam logic [1:0] REG_ADDR  = 2'b10;
  localparam logic [1:0] REG_CKSUM = 2'b11;

  localparam int CTRL_START  = 0;
  localparam int CTRL_FINISH = 1;

  // STAT = {26'b0, drop_err, ovf, pending, state[1:0], download_mode}
  function automatic logic [31:0] pack_stat(logic dm, dl_state_e st, logic pending,
                                            logic ovf, logic drop_err);
    pack_stat = {26'b0, drop_err, ovf, pending, st, dm};
  endfunction

endpackage

// File: rtl/dl_word_packer.sv
// Little-endian byte-to-word packer: byte lane shift-in, byte count, zero-padded partial word.
// Captures a byte the cycle push is high; caller must not push while a full word is held.
`timescale 1ns/1ps
module dl_word_packer (
  input  logic        hb_clk,
  input  logic        rst_sync,
  input  logic        clr,
  input  logic        push,
  input  logic        discard,
  input  logic [7:0]  byte_in,
  output logic [2:0]  byte_cnt,
  output logic [31:0] word,
  output logic        last
);

  assign last = (byte_cnt == 3'd3);

  // Lanes are cleared on every restart so a partial word is already zero-padded.
  always_ff @(posedge hb_clk) begin
    if (rst_sync || clr) begin
      byte_cnt <= 3'd0;
      word     <= 32'd0;
    end else if (push) begin
      if (last && discard) begin
        byte_cnt <= 3'd0;
        word     <= 32'd0;
      end else begin
        word[{byte_cnt[1:0], 3'b000} +: 8] <= byte_in;
        byte_cnt <= byte_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/instr_download_ctrl.sv
// XT_HB slave streaming program bytes into instruction RAM as packed words at an auto-incrementing address.
// Read data 1 cycle after ren; an imem write is held stable until imem_ready, bytes arriving meanwhile are dropped.
`timescale 1ns/1ps
module instr_download_ctrl
  import instr_download_ctrl_pkg::*;
#(
  parameter  int IMEM_WORDS = 2048,
  localparam int AW = $clog2(IMEM_WORDS)
) (
  input  logic            hb_clk,
  input  logic            rst_sync,
  input  hb_slave_t       xt_hb,
  input  sel_t            sel,
  output logic [31:0]     rdata,
  input  logic            download_mode,
  output logic            imem_we,
  output logic [AW-1:0]   imem_addr,
  output logic [31:0]     imem_wdata,
  input  logic            imem_ready
);

  dl_state_e     state;
  logic [AW-1:0] addr;
  logic [31:0]   cksum;
  logic          ovf;
  logic          drop_err;

  logic [2:0]    pk_cnt;
  logic [31:0]   pk_word;
  logic          pk_last;

  logic [1:0]    woff;
  logic          ctrl_wr, data_wr, addr_wr;
  logic          start, finish, push, accept;
  logic          unused_bus;

  assign woff    = xt_hb.waddr[1:0];
  assign ctrl_wr = sel.wen && (woff == REG_CTRL);
  assign data_wr = sel.wen && (woff == REG_DATA);
  assign addr_wr = sel.wen && (woff == REG_ADDR);
  assign start   = ctrl_wr && xt_hb.wdata[CTRL_START];
  assign finish  = ctrl_wr && xt_hb.wdata[CTRL_FINISH] && !start;
  assign push    = data_wr && download_mode && (state == DL_LOAD);
  assign accept  = imem_we && imem_ready;

  assign imem_addr  = addr;
  assign imem_wdata = pk_word;
  assign unused_bus = ^{xt_hb.raddr, xt_hb.waddr, xt_hb.wdata};

  dl_word_packer u_packer (
    .hb_clk   (hb_clk),
    .rst_sync (rst_sync),
    .clr      (start || accept),
    .push     (push),
    .discard  (ovf),
    .byte_in  (xt_hb.wdata[7:0]),
    .byte_cnt (pk_cnt),
    .word     (pk_word),
    .last     (pk_last)
  );

  always_ff @(posedge hb_clk) begin
    if (rst_sync) begin
      state    <= DL_IDLE;
      imem_we  <= 1'b0;
      addr     <= '0;
      cksum    <= 32'd0;
      ovf      <= 1'b0;
      drop_err <= 1'b0;
    end else if (start) begin
      state    <= DL_LOAD;
      imem_we  <= 1'b0;
      addr     <= '0;
      cksum    <= 32'd0;
      ovf      <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      if (push)
        cksum <= cksum + {24'b0, xt_hb.wdata[7:0]};
      if (data_wr && download_mode && (state == DL_WRITE || state == DL_FLUSH))
        drop_err <= 1'b1;
      // The last RAM word saturates the address; later words are counted but never written.
      if (accept) begin
        imem_we <= 1'b0;
        if (addr == AW'(IMEM_WORDS - 1))
          ovf <= 1'b1;
        else
          addr <= addr + 1'b1;
      end
      case (state)
        DL_IDLE: begin
          if (addr_wr) begin
            addr <= xt_hb.wdata[AW-1:0];
            ovf  <= 1'b0;
          end
        end
        DL_LOAD: begin
          if (push && pk_last && !ovf) begin
            state   <= DL_WRITE;
            imem_we <= 1'b1;
          end else if (finish) begin
            state <= DL_FLUSH;
          end
        end
        DL_WRITE: begin
          if (accept)
            state <= DL_LOAD;
        end
        DL_FLUSH: begin
          if (accept)
            state <= DL_IDLE;
          else if (!imem_we) begin
            if (pk_cnt != 3'd0 && !ovf)
              imem_we <= 1'b1;
            else
              state <= DL_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge hb_clk) begin
    if (rst_sync) begin
      rdata <= 32'd0;
    end else if (sel.ren) begin
      case (xt_hb.raddr[1:0])
        REG_CTRL:  rdata <= pack_stat(download_mode, state, imem_we, ovf, drop_err);
        REG_DATA:  rdata <= 32'd0;
        REG_ADDR:  rdata <= 32'(addr);
        REG_CKSUM: rdata <= cksum;
      endcase
    end else begin
      rdata <= 32'd0;
    end
  end

endmodule

// File: tb/tb_instr_download_ctrl.sv
// Directed bench for instr_download_ctrl with a 4-word RAM: vector table plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_instr_download_ctrl;
  import instr_download_ctrl_pkg::*;

  logic        hb_clk = 1'b0;
  logic        rst_sync;
  hb_slave_t   xt_hb;
  sel_t        sel;
  logic [31:0] rdata;
  logic        download_mode;
  logic        imem_we;
  logic [1:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        imem_ready;

  int checks = 0;
  int failures = 0;

  logic [1:0]  log_addr[$];
  logic [31:0] log_data[$];

  instr_download_ctrl #(.IMEM_WORDS(4)) dut (
    .hb_clk        (hb_clk),
    .rst_sync      (rst_sync),
    .xt_hb         (xt_hb),
    .sel           (sel),
    .rdata         (rdata),
    .download_mode (download_mode),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata),
    .imem_ready    (imem_ready)
  );

  always #5 hb_clk = ~hb_clk;

  always @(posedge hb_clk)
    if (!rst_sync && imem_we && imem_ready) begin
      log_addr.push_back(imem_addr);
      log_data.push_back(imem_wdata);
    end

  typedef struct {
    logic        wr;
    logic [1:0]  off;
    logic [31:0] dat;
    logic        dm;
    logic [31:0] exp;
  } vec_t;

  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

  task automatic step();
    @(negedge hb_clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] off, input logic [31:0] d);
    xt_hb.waddr = {2'b00, off};
    xt_hb.wdata = d;
    sel.wen = 1'b1;
    step();
    sel.wen = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] off, input logic [31:0] exp, input string name);
    xt_hb.raddr = {2'b00, off};
    sel.ren = 1'b1;
    step();
    sel.ren = 1'b0;
    check(name, rdata, exp);
  endtask

  task automatic check_log(input string name, input int n);
    check({name, "_count"}, 32'(log_addr.size()), 32'(n));
  endtask

  vec_t tbl[27];
  logic [7:0]  bytes[20];
  logic [31:0] sum;
  logic [31:0] word;

  initial begin
    rst_sync = 1'b1;
    xt_hb = '0;
    sel = '0;
    download_mode = 1'b0;
    imem_ready = 1'b1;
    step();
    step();
    rst_sync = 1'b0;
    check("rst_we", {31'b0, imem_we}, 32'd0);
    check("rst_addr", {30'b0, imem_addr}, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_rdata", rdata, 32'd0);

    tbl = '{
      '{RD, REG_CTRL,  32'h0,  1'b1, 32'h1},
      '{WR, REG_CTRL,  32'h1,  1'b1, 32'h0},
      '{RD, REG_CTRL,  32'h0,  1'b1, 32'h3},
      '{WR, REG_DATA,  32'h11, 1'b1, 32'h0},
      '{WR, REG_DATA,  32'h22, 1'b1, 32'h0},
      '{WR, REG_DATA,  32'h33, 1'b1, 32'h0},
      '{WR, REG_DATA,  32'h44, 1'b1, 32'h0},
      '{RD, REG_CTRL,  32'h0,  1'b1, 32'hD},
      '{RD, REG_CKSUM, 32'h0,  1'b1, 32'hAA},
      '{RD, REG_ADDR,  32'h0,  1'b1, 32'h1},
      '{RD, REG_CTRL,  32'h0,  1'b1, 32'h3},
      '{WR, REG_DATA,  32'h55, 1'b0, 32'h0},
      '{RD, REG_CKSUM, 32'h0,  1'b0, 32'hAA},
      '{RD, REG_CTRL,  32'h0,  1'b0, 32'h2},
      '{WR, REG_CTRL,  32'h2,  1'b1, 32'h0},
      '{RD, REG_CTRL,  32'h0,  1'b1, 32'h7},
      '{RD, REG_CTRL,  32'h0,  1'b1, 32'h1},
      '{RD, REG_ADDR,  32'h0,  1'b1, 32'h1},
      '{WR, REG_ADDR,  32'h3,  1'b1, 32'h0},
      '{RD, REG_ADDR,  32'h0,  1'b1, 32'h3},
      '{WR, REG_DATA,  32'h66, 1'b1, 32'h0},
      '{RD, REG_CTRL,  32'h0,  1'b1, 32'h1},
      '{WR, REG_CTRL,  32'h1,  1'b1, 32'h0},
      '{RD, REG_ADDR,  32'h0,  1'b1, 32'h0},
      '{WR, REG_ADDR,  32'h2,  1'b1, 32'h0},
      '{RD, REG_ADDR,  32'h0,  1'b1, 32'h0},
      '{RD, REG_CKSUM, 32'h0,  1'b1, 32'h0}
    };
    for (int i = 0; i < 27; i++) begin
      download_mode = tbl[i].dm;
      if (tbl[i].wr) bus_write(tbl[i].off, tbl[i].dat);
      else bus_read(tbl[i].off, tbl[i].exp, $sformatf("vec%0d", i));
    end
    check_log("tbl_log", 1);
    if (log_addr.size() == 1) begin
      check("tbl_log_addr", {30'b0, log_addr[0]}, 32'd0);
      check("tbl_log_data", log_data[0], 32'h44332211);
    end

    // RAM stall: request held stable, concurrent byte dropped
    download_mode = 1'b1;
    imem_ready = 1'b0;
    bus_write(REG_CTRL, 32'h1);
    log_addr.delete();
    log_data.delete();
    for (int b = 1; b <= 4; b++) bus_write(REG_DATA, 32'(b));
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall_we%0d", i), {31'b0, imem_we}, 32'd1);
      check($sformatf("stall_addr%0d", i), {30'b0, imem_addr}, 32'd0);
      check($sformatf("stall_data%0d", i), imem_wdata, 32'h04030201);
      if (i == 2) bus_write(REG_DATA, 32'h99);
      else step();
    end
    bus_read(REG_CTRL, 32'h2D, "stall_stat");
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    check("stall_we_drop", {31'b0, imem_we}, 32'd0);
    check_log("stall_log", 1);
    if (log_data.size() == 1) check("stall_log_data", log_data[0], 32'h04030201);
    bus_read(REG_CKSUM, 32'h0000000A, "stall_cksum");
    bus_read(REG_ADDR, 32'h1, "stall_addr");

    // FINISH with two bytes pending: zero-padded word
    imem_ready = 1'b1;
    bus_write(REG_CTRL, 32'h1);
    log_addr.delete();
    log_data.delete();
    bus_write(REG_DATA, 32'hAB);
    bus_write(REG_DATA, 32'hCD);
    bus_write(REG_CTRL, 32'h2);
    step();
    step();
    step();
    check_log("flush_log", 1);
    if (log_data.size() == 1) begin
      check("flush_addr", {30'b0, log_addr[0]}, 32'd0);
      check("flush_data", log_data[0], 32'h0000CDAB);
    end
    bus_read(REG_CTRL, 32'h1, "flush_stat");
    bus_read(REG_ADDR, 32'h1, "flush_next_addr");

    // Same-cycle read and write of ADDR returns the old value
    xt_hb.raddr = {2'b00, REG_ADDR};
    xt_hb.waddr = {2'b00, REG_ADDR};
    xt_hb.wdata = 32'h2;
    sel.ren = 1'b1;
    sel.wen = 1'b1;
    step();
    sel = '0;
    check("rw_same_old", rdata, 32'h1);
    bus_read(REG_ADDR, 32'h2, "rw_same_new");

    // Overflow: 20 bytes into a 4-word RAM
    bus_write(REG_CTRL, 32'h1);
    log_addr.delete();
    log_data.delete();
    sum = 32'd0;
    for (int i = 0; i < 20; i++) begin
      bytes[i] = 8'((i * 37 + 9) & 8'hFF);
      sum = sum + {24'b0, bytes[i]};
      bus_write(REG_DATA, {24'b0, bytes[i]});
      if (i % 4 == 3) step();
    end
    check_log("ovf_log", 4);
    for (int k = 0; k < 4; k++) begin
      word = {bytes[4*k+3], bytes[4*k+2], bytes[4*k+1], bytes[4*k]};
      if (log_data.size() > k) begin
        check($sformatf("ovf_addr%0d", k), {30'b0, log_addr[k]}, 32'(k));
        check($sformatf("ovf_data%0d", k), log_data[k], word);
      end
    end
    bus_read(REG_CTRL, 32'h13, "ovf_stat");
    bus_read(REG_CKSUM, sum, "ovf_cksum");
    bus_read(REG_ADDR, 32'h3, "ovf_addr_sat");

    // START aborts a pending write, then reset mid-write
    imem_ready = 1'b0;
    bus_write(REG_CTRL, 32'h1);
    log_addr.delete();
    log_data.delete();
    for (int b = 5; b <= 8; b++) bus_write(REG_DATA, 32'(b));
    check("abort_pre_we", {31'b0, imem_we}, 32'd1);
    bus_write(REG_CTRL, 32'h1);
    check("abort_we", {31'b0, imem_we}, 32'd0);
    bus_read(REG_ADDR, 32'h0, "abort_addr");
    for (int b = 5; b <= 8; b++) bus_write(REG_DATA, 32'(b));
    check("rstw_pre_we", {31'b0, imem_we}, 32'd1);
    rst_sync = 1'b1;
    step();
    rst_sync = 1'b0;
    check("rstw_we", {31'b0, imem_we}, 32'd0);
    check("rstw_imem_addr", {30'b0, imem_addr}, 32'd0);
    check("rstw_wdata", imem_wdata, 32'd0);
    download_mode = 1'b0;
    bus_read(REG_CTRL, 32'h0, "rstw_stat");
    bus_read(REG_ADDR, 32'h0, "rstw_addr");
    bus_read(REG_CKSUM, 32'h0, "rstw_cksum");
    check_log("rstw_log", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
